// File: rtl/puf_pkg.sv
// Shared types and constants for the PUF response collector.
package puf_pkg;

  localparam int unsigned PUF_CHAL_W = 2;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StSample,
    StShift,
    StDone
  } puf_state_e;

endpackage

// File: rtl/puf_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
module puf_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Both stages clear on reset so no stale sample survives an abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/puf_resp_collector.sv
// Collects an N_BITS response word from a PUF generator, one bit per challenge step.
// Optional build macro: PUF_MAJORITY_VOTE_EN enables N_SAMPLES-way majority voting per bit.
module puf_resp_collector
  import puf_pkg::*;
#(
  parameter int unsigned N_BITS     = 8,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned N_SAMPLES  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  puf_out,
  output logic                  puf_enable,
  output logic [PUF_CHAL_W-1:0] puf_challenge,
  output logic [N_BITS-1:0]     resp_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  busy
);

  puf_state_e            state_q, state_d;
  logic [7:0]            settle_q, settle_d;
  logic [4:0]            idx_q, idx_d;
  logic [PUF_CHAL_W-1:0] chal_q, chal_d;
  logic                  en_q, en_d;
  logic [N_BITS-1:0]     data_q, data_d;
  logic                  puf_sync;
  logic                  dec_bit;

  puf_sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (puf_out),
    .q_o (puf_sync)
  );

`ifdef PUF_MAJORITY_VOTE_EN
  logic [3:0] samp_q, samp_d;
  logic [3:0] ones_q, ones_d;
`else
  logic       bit_q, bit_d;
  // Parameter is meaningless without voting; keep it referenced.
  logic [3:0] unused_n_samples;
  assign unused_n_samples = 4'(N_SAMPLES);
`endif

  // Next-state logic: sequencing of settle / sample / shift per response bit.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    idx_d    = idx_q;
    chal_d   = chal_q;
    en_d     = en_q;
    data_d   = data_q;
`ifdef PUF_MAJORITY_VOTE_EN
    samp_d   = samp_q;
    ones_d   = ones_q;
    dec_bit  = (ones_q >= 4'((N_SAMPLES + 1) / 2));
`else
    bit_d    = bit_q;
    dec_bit  = bit_q;
`endif

    case (state_q)
      StIdle: begin
        if (start) begin
          idx_d    = '0;
          data_d   = '0;
          en_d     = 1'b1;
          chal_d   = '0;
          settle_d = 8'(SETTLE_CYC - 1);
          state_d  = StSettle;
        end
      end
      StSettle: begin
        if (settle_q == 8'd0) begin
          state_d = StSample;
`ifdef PUF_MAJORITY_VOTE_EN
          samp_d  = 4'(N_SAMPLES - 1);
          ones_d  = '0;
`endif
        end else begin
          settle_d = settle_q - 8'd1;
        end
      end
      StSample: begin
`ifdef PUF_MAJORITY_VOTE_EN
        ones_d = ones_q + 4'(puf_sync);
        if (samp_q == 4'd0) begin
          state_d = StShift;
        end else begin
          samp_d = samp_q - 4'd1;
        end
`else
        bit_d   = puf_sync;
        state_d = StShift;
`endif
      end
      StShift: begin
        // Shift left so bit index 0 ends up at the MSB.
        data_d = (data_q << 1) | N_BITS'(dec_bit);
        if (idx_q == 5'(N_BITS - 1)) begin
          en_d    = 1'b0;
          state_d = StDone;
        end else begin
          idx_d    = idx_q + 5'd1;
          chal_d   = idx_q[PUF_CHAL_W-1:0] + 2'd1;
          settle_d = 8'(SETTLE_CYC - 1);
          state_d  = StSettle;
        end
      end
      StDone: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any collection in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      settle_q <= '0;
      idx_q    <= '0;
      chal_q   <= '0;
      en_q     <= 1'b0;
      data_q   <= '0;
`ifdef PUF_MAJORITY_VOTE_EN
      samp_q   <= '0;
      ones_q   <= '0;
`else
      bit_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      idx_q    <= idx_d;
      chal_q   <= chal_d;
      en_q     <= en_d;
      data_q   <= data_d;
`ifdef PUF_MAJORITY_VOTE_EN
      samp_q   <= samp_d;
      ones_q   <= ones_d;
`else
      bit_q    <= bit_d;
`endif
    end
  end

  // Outputs come straight from registers so reset clears them without a clock edge.
  always_comb begin
    puf_enable    = en_q;
    puf_challenge = chal_q;
    resp_data     = data_q;
    resp_valid    = (state_q == StDone);
    busy          = (state_q != StIdle);
  end

endmodule

// File: tb/tb_puf_resp_collector.sv
// Self-checking bench for puf_resp_collector (default parameters).
module tb_puf_resp_collector;

  localparam int NB = 8;
  localparam int SC = 16;
`ifdef PUF_MAJORITY_VOTE_EN
  localparam int S = 5;
`else
  localparam int S = 1;
`endif
  localparam int P      = SC + S + 1;
  localparam int LAT    = NB * P;
  localparam int BUDGET = LAT + 200;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          puf_out;
  logic          puf_enable;
  logic [1:0]    puf_challenge;
  logic [NB-1:0] resp_data;
  logic          resp_valid;
  logic          resp_ready;
  logic          busy;

  int checks = 0;
  int failures = 0;
  logic [NB-1:0] exp_q[$];

  typedef struct {
    int          mode;    // 0 const0, 1 const1, 2 chal[0], 3 chal[1], 4 ~chal[0], 5 window
    int          k;       // sample cycles forced high in window mode
    logic [NB-1:0] exp;
    bit          chk_chal;
    int          hold;
    bit          midstart;
  } vec_t;

  vec_t vecs[$];

  puf_resp_collector dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .puf_out       (puf_out),
    .puf_enable    (puf_enable),
    .puf_challenge (puf_challenge),
    .resp_data     (resp_data),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural PUF; raw value at offset o is consumed by the sample edge o+3.
  function automatic logic puf_model(input int mode, input int k, input int cnt,
                                     input logic [1:0] chal);
    int o;
    o = cnt % P;
    case (mode)
      0: return 1'b0;
      1: return 1'b1;
      2: return chal[0];
      3: return chal[1];
      4: return ~chal[0];
      default: return (o + 3 >= SC + 1) && (o + 3 <= SC + k);
    endcase
  endfunction

  task automatic run_collect(input vec_t v);
    int            cnt;
    logic [1:0]    last;
    logic [15:0]   seq;
    int            nchg;
    logic [NB-1:0] e;
    exp_q.push_back(v.exp);
    puf_out = puf_model(v.mode, v.k, 0, 2'd0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0;
    chk("enable_after_start", {31'd0, puf_enable}, 32'd1);
    last = puf_challenge;
    seq  = {14'd0, puf_challenge};
    nchg = 1;
    puf_out = puf_model(v.mode, v.k, cnt, puf_challenge);
    while (!resp_valid && cnt < BUDGET) begin
      @(posedge clk); #1;
      cnt++;
      start = v.midstart && (cnt == 20);
      if (puf_challenge != last) begin
        seq  = {seq[13:0], puf_challenge};
        nchg++;
        last = puf_challenge;
      end
      puf_out = puf_model(v.mode, v.k, cnt, puf_challenge);
    end
    start = 1'b0;
    puf_out = 1'b0;
    chk("latency", cnt, LAT);
    e = exp_q.pop_front();
    chk("resp_data", {24'd0, resp_data}, {24'd0, e});
    if (!resp_valid) return;
    chk("enable_low_done", {31'd0, puf_enable}, 32'd0);
    if (v.chk_chal) begin
      chk("chal_seq", seq, 32'h1B1B);
      chk("chal_count", nchg, 8);
    end
    for (int i = 0; i < v.hold; i++) begin
      start = (i == 10);
      @(posedge clk); #1;
      start = 1'b0;
      chk("hold_stable", {23'd0, resp_valid, resp_data}, {23'd0, 1'b1, e});
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("idle_after_ready", {30'd0, busy, resp_valid}, 32'd0);
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    start = 1'b0;
    puf_out = 1'b0;
    resp_ready = 1'b0;
    #1;
    chk("reset_outputs", {20'd0, puf_enable, puf_challenge, resp_data, resp_valid, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    vecs.push_back('{1, 0, 8'hFF, 1'b0, 50, 1'b0});
    vecs.push_back('{0, 0, 8'h00, 1'b0, 0, 1'b1});
    vecs.push_back('{2, 0, 8'h55, 1'b1, 0, 1'b0});
    vecs.push_back('{3, 0, 8'h33, 1'b0, 0, 1'b0});
    vecs.push_back('{4, 0, 8'hAA, 1'b0, 0, 1'b0});
`ifdef PUF_MAJORITY_VOTE_EN
    vecs.push_back('{5, 2, 8'h00, 1'b0, 0, 1'b0});
    vecs.push_back('{5, 3, 8'hFF, 1'b0, 0, 1'b0});
`else
    vecs.push_back('{5, 1, 8'hFF, 1'b0, 0, 1'b0});
    vecs.push_back('{5, 0, 8'h00, 1'b0, 0, 1'b0});
`endif

    // First start straight after reset release, no idle cycle in between.
    foreach (vecs[i]) run_collect(vecs[i]);

    // Abort in the middle of SAMPLE for bit 3.
    @(posedge clk); #1;
    puf_out = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0;
    while (cnt < 3 * P + SC) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("busy_before_abort", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_outputs", {20'd0, puf_enable, puf_challenge, resp_data, resp_valid, busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    puf_out = 1'b0;
    run_collect('{2, 0, 8'h55, 1'b1, 0, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/puf_resp_collector.md
PUF_RESP_COLLECTOR -- requirements
Module: puf_resp_collector

Interface
REQ-001 Parameter N_BITS, default 8: response word width, one bit per challenge step, legal range 1..32.
REQ-002 Parameter SETTLE_CYC, default 16: clk cycles waited after each challenge change before sampling, legal range 1..255.
REQ-003 Parameter N_SAMPLES, default 5: samples per bit when voting is enabled; odd values only, legal range 1..15.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset; asynchronous assert, active-high.
REQ-006 start  input  1  pulse; begins one collection when idle.
REQ-007 puf_out  input  1  raw output_signal from the PUF generator; asynchronous to clk.
REQ-008 puf_enable  output  1  drives the generator enable.
REQ-009 puf_challenge  output  2  drives the generator control_input.
REQ-010 resp_data  output  N_BITS  collected response word.
REQ-011 resp_valid  output  1  resp_data is valid.
REQ-012 resp_ready  input  1  consumer accepts resp_data.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 puf_out shall pass through a two-flop synchronizer before any use; the added 2-cycle delay lies within SETTLE_CYC.
REQ-015 FSM states: IDLE, SETTLE, SAMPLE, SHIFT, DONE.
REQ-016 IDLE: when start=1, clear bit index to 0, clear resp_data to 0, assert puf_enable, set puf_challenge=0, load settle counter, and enter SETTLE; start in any other state is ignored.
REQ-017 SETTLE: count SETTLE_CYC cycles, then enter SAMPLE.
REQ-018 SAMPLE: take one synchronized sample per cycle; ones are counted with a 4-bit counter.
REQ-019 SHIFT (1 cycle): shift the decided bit into resp_data LSB, shifting left, so bit index 0 ends at the MSB.
REQ-020 SHIFT, not the last bit: increment index, set puf_challenge = new index[1:0] (wrapping 3->0), reload the settle counter, and enter SETTLE.
REQ-021 SHIFT, last bit (index = N_BITS-1): deassert puf_enable and enter DONE with resp_valid=1.
REQ-022 DONE: hold resp_data and resp_valid stable until resp_ready=1; on that cycle clear resp_valid and enter IDLE.
REQ-023 resp_ready is ignored outside DONE.
REQ-024 puf_enable is high from the cycle after start through SHIFT of the last bit, and low otherwise.
REQ-025 Latency from the start edge to resp_valid = N_BITS*(SETTLE_CYC+S+1) cycles, where S is the samples per bit.

Reset
REQ-026 rst=1 shall immediately force IDLE, puf_enable=0, puf_challenge=0, resp_data=0, resp_valid=0, busy=0, clear all counters and synchronizer flops, and abort any collection in progress without producing a partial response.
REQ-027 After rst deasserts, the first start shall be accepted on the first rising edge.

Configuration
REQ-028 Macro PUF_MAJORITY_VOTE_EN, when defined: SAMPLE lasts N_SAMPLES cycles and the bit is 1 when the ones count >= (N_SAMPLES+1)/2 (S = N_SAMPLES).
REQ-029 Macro PUF_MAJORITY_VOTE_EN, when undefined: SAMPLE lasts 1 cycle, the bit equals the single synchronized sample, N_SAMPLES is unused, and the vote counter is not built (S = 1).

Structure
REQ-030 Shared package puf_pkg shall hold the FSM state enum typedef and constant PUF_CHAL_W=2.
REQ-031 One sub-module, puf_sync_2ff (two-flop synchronizer with asynchronous active-high reset), shall be instantiated for puf_out.

Verification
REQ-032 Defaults, voting on, puf_out=1 constant, start pulse -> resp_data=8'hFF, resp_valid after 8*(16+5+1)=176 cycles, puf_enable low in DONE.
REQ-033 Behavioural model with puf_out = challenge[0] -> resp_data=8'b0101_0101, and puf_challenge observed cycling 0,1,2,3,0,1,2,3.
REQ-034 Voting on, puf_out forced 1 for 2 of 5 sample cycles of each bit -> every bit 0; forced 1 for 3 of 5 -> every bit 1.
REQ-035 resp_ready held 0 for 50 cycles in DONE -> resp_data and resp_valid stable throughout; resp_ready=1 -> IDLE next cycle and busy=0; start during busy -> no effect.
REQ-036 rst asserted mid-SAMPLE of bit 3 -> all outputs 0 immediately with no clock edge; a following start -> a complete, correct 8-bit response.
REQ-037 Voting off -> latency 8*(16+1+1)=144 cycles; puf_out=1 -> resp_data=8'hFF.
